fifo_rd_drain: RTL and testbench

- Read-side engine for the FIFO: pulls words out of the FIFO storage and delivers them downstream on a valid/ready stream.
- Drives r_en into the FIFO pointer controller and watches its registered empty flag.
- Absorbs the one-cycle synchronous read latency of the FIFO storage with a 2-entry output buffer, giving full throughput under backpressure.
- Never reads an empty FIFO.

---
 rtl/fifo_rd_drain.sv | 120 ++++++++++++
 tb/tb_fifo_rd_drain.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_drain.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_drain
// Description : Read-side drain engine for a FIFO. Issues r_en towards the
//               FIFO pointer controller, absorbs the one-cycle storage read
//               latency in a 2-entry output buffer and presents the words on
//               a valid/ready stream at full throughput.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  empty,
    output logic                  r_en,
    input  logic [DATA_WIDTH-1:0] r_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  busy
);

    localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Buffer occupancy: number of words held in head/tail
    typedef enum logic [1:0] {
        OCC_ZERO = 2'd0,
        OCC_ONE  = 2'd1,
        OCC_TWO  = 2'd2
    } occ_e;

    occ_e                  occ_q, occ_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic                  inflight_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    logic                  w_pop;
    logic                  w_capture;
    logic                  w_room;

    assign w_pop     = m_valid & m_ready;
    // A read issued last cycle returns its word on r_data this cycle
    assign w_capture = inflight_q;

    // occ + inflight < 2: there is a free slot for a new read even without a pop
    assign w_room    = (occ_q == OCC_ZERO) | ((occ_q == OCC_ONE) & ~inflight_q);

    // A read is only issued when its word is guaranteed a slot on return;
    // a pop this cycle frees one slot, which covers the read issued now.
    assign r_en      = ~rst & ~empty & (w_room | w_pop);

    assign m_valid   = (occ_q != OCC_ZERO);
    assign m_data    = head_q;
    assign rd_count  = cnt_q;
    assign busy      = m_valid | inflight_q;

    // Next-state of the 2-entry buffer from capture/pop combination
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case (occ_q)
            OCC_ZERO: begin
                if (w_capture) begin
                    occ_d  = OCC_ONE;
                    head_d = r_data;
                end
            end
            OCC_ONE: begin
                if (w_capture && w_pop) begin
                    head_d = r_data;
                end else if (w_capture) begin
                    occ_d  = OCC_TWO;
                    tail_d = r_data;
                end else if (w_pop) begin
                    occ_d  = OCC_ZERO;
                end
            end
            OCC_TWO: begin
                // Capture without pop cannot happen here: r_en is gated by room
                if (w_pop) begin
                    head_d = tail_q;
                    if (w_capture) begin
                        tail_d = r_data;
                    end else begin
                        occ_d  = OCC_ONE;
                    end
                end
            end
            default: begin
                occ_d = OCC_ZERO;
            end
        endcase
    end

    // State registers, in-flight tracking and delivered-word counter
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q      <= OCC_ZERO;
            head_q     <= '0;
            tail_q     <= '0;
            inflight_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            occ_q      <= occ_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            inflight_q <= r_en;
            if (w_pop) begin
                cnt_q <= cnt_q + c_cnt_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_drain
// Description : Self-checking bench for fifo_rd_drain. A queue-based FIFO
//               model feeds the DUT; a word-level reference tracks the
//               pushed sequence, read/pop counts and buffer fill.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_drain;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          empty;
    logic          r_en;
    logic [DW-1:0] r_data;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [CW-1:0] rd_count;
    logic          busy;

    fifo_rd_drain #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .empty    (empty),
        .r_en     (r_en),
        .r_data   (r_data),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .rd_count (rd_count),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // FIFO storage + pointer controller model: registered empty, 1-cycle read
    logic [DW-1:0] fq[$];
    logic [DW-1:0] pend[$];

    always @(posedge clk) begin
        if (rst) begin
            fq.delete();
            pend.delete();
            empty  <= 1'b1;
            r_data <= '0;
        end else begin
            if (r_en && fq.size() > 0) r_data <= fq.pop_front();
            while (pend.size() > 0) fq.push_back(pend.pop_front());
            empty <= (fq.size() == 0);
        end
    end

    // Word-level reference: expected order, counts of reads and pops
    logic [DW-1:0] expq[$];
    int   reads, pops, cyc;
    int   first_ren, last_ren, first_pop, last_pop;
    int   outst_prev;
    logic prev_ren, prev_hold;
    logic [DW-1:0] prev_data;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            expq.delete();
            reads = 0; pops = 0;
            first_ren = -1; last_ren = -1; first_pop = -1; last_pop = -1;
            outst_prev = 0; prev_ren = 1'b0; prev_hold = 1'b0; prev_data = '0;
        end else begin
            // Words read but not yet delivered live in the buffer or in flight
            chk("busy", busy, outst_prev != 0);
            chk("m_valid", m_valid, (outst_prev - int'(prev_ren)) > 0);
            chk("rd_count", rd_count, pops % (1 << CW));
            if (prev_hold) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, prev_data);
            end
            if (r_en) begin
                chk("ren_while_empty", empty, 0);
                reads++;
                if (first_ren < 0) first_ren = cyc;
                last_ren = cyc;
            end
            if (m_valid && m_ready) begin
                if (expq.size() == 0) chk("pop_extra", 1, 0);
                else                  chk("pop_data", m_data, expq.pop_front());
                pops++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
            chk("buffer_bound", (reads - pops) <= 2, 1);
            outst_prev = reads - pops;
            prev_ren   = r_en;
            prev_hold  = m_valid & ~m_ready;
            prev_data  = m_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] w);
        pend.push_back(w);
        expq.push_back(w);
    endtask

    // mode 0: ready always high, 1: ready toggles 1,0,..., 2: ready low for hold cycles
    typedef struct {
        int          nwords;
        logic [7:0]  base;
        int          mode;
        int          hold;
        int          exp_hold_reads;
        int          exp_cnt;
    } scn_t;

    task automatic run_scn(input scn_t s, input int idx);
        bit done;
        do_reset(2);
        for (int i = 0; i < s.nwords; i++) push(8'(int'(s.base) + i));
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            if (s.mode == 2 && c == s.hold) begin
                chk($sformatf("s%0d_hold_reads", idx), reads, s.exp_hold_reads);
                chk($sformatf("s%0d_hold_valid", idx), m_valid, 1);
                chk($sformatf("s%0d_hold_data", idx), m_data, s.base);
            end
            case (s.mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (c % 2 == 0);
                default: m_ready = (c >= s.hold);
            endcase
            tick();
            done = (pops == s.nwords) && !busy && (c > 2);
        end
        chk($sformatf("s%0d_timeout", idx), done, 1);
        chk($sformatf("s%0d_pops", idx), pops, s.nwords);
        chk($sformatf("s%0d_reads", idx), reads, s.nwords);
        chk($sformatf("s%0d_rd_count", idx), rd_count, s.exp_cnt);
        chk($sformatf("s%0d_busy", idx), busy, 0);
        if (s.mode == 0)
            chk($sformatf("s%0d_ren_span", idx), last_ren - first_ren, s.nwords - 1);
        if (s.mode != 1)
            chk($sformatf("s%0d_pop_span", idx), last_pop - first_pop, s.nwords - 1);
        m_ready = 1'b0;
    endtask

    scn_t tbl[5];
    int   total;
    bit   done_r;

    initial begin
        tbl[0] = '{nwords: 1,  base: 8'hA5, mode: 0, hold: 0, exp_hold_reads: 0, exp_cnt: 1};
        tbl[1] = '{nwords: 4,  base: 8'h01, mode: 0, hold: 0, exp_hold_reads: 0, exp_cnt: 4};
        tbl[2] = '{nwords: 6,  base: 8'h10, mode: 2, hold: 8, exp_hold_reads: 2, exp_cnt: 6};
        tbl[3] = '{nwords: 8,  base: 8'h20, mode: 1, hold: 0, exp_hold_reads: 0, exp_cnt: 8};
        tbl[4] = '{nwords: 17, base: 8'h40, mode: 0, hold: 0, exp_hold_reads: 0, exp_cnt: 1};

        // Reset state and idle with an empty FIFO
        tick();
        do_reset(2);
        chk("rst_r_en", r_en, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_rd_count", rd_count, 0);
        chk("rst_busy", busy, 0);
        repeat (10) tick();
        chk("idle_reads", reads, 0);
        chk("idle_r_en", r_en, 0);

        // Single word: exact latency from empty falling to m_valid
        do_reset(2);
        m_ready = 1'b1;
        push(8'hA5);
        tick();
        chk("lat_empty_low", empty, 0);
        chk("lat_r_en_c", r_en, 1);
        chk("lat_valid_c", m_valid, 0);
        tick();
        chk("lat_r_en_c1", r_en, 0);
        chk("lat_valid_c1", m_valid, 0);
        chk("lat_busy_c1", busy, 1);
        tick();
        chk("lat_valid_c2", m_valid, 1);
        chk("lat_data_c2", m_data, 8'hA5);
        tick();
        chk("lat_valid_c3", m_valid, 0);
        chk("lat_count", rd_count, 1);
        chk("lat_busy_c3", busy, 0);
        m_ready = 1'b0;

        // Table-driven scenarios
        for (int k = 0; k < 5; k++) run_scn(tbl[k], k);

        // Reset in the middle of a burst discards everything
        do_reset(2);
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'(8'h60 + i));
        repeat (6) tick();
        chk("mr_full_valid", m_valid, 1);
        m_ready = 1'b1;
        tick();
        chk("mr_busy_before", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_valid", m_valid, 0);
        chk("mr_rd_count", rd_count, 0);
        chk("mr_busy", busy, 0);
        chk("mr_r_en", r_en, 0);
        m_ready = 1'b0;

        // Randomised traffic: random pushes and random backpressure
        do_reset(2);
        total = 0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                push(8'($urandom));
                total++;
            end
            m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        m_ready = 1'b1;
        done_r  = 1'b0;
        for (int c = 0; c < 300 && !done_r; c++) begin
            tick();
            done_r = (pops == total) && !busy;
        end
        chk("rnd_timeout", done_r, 1);
        chk("rnd_pops", pops, total);
        chk("rnd_rd_count", rd_count, total % (1 << CW));
        chk("rnd_left", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
